fetch_stage: RTL

Instruction-fetch stage and IF/ID pipeline register of the pipelined RV32I core. Holds the program counter and presents it to instruction memory. Captures the returned instruction with its PC and PC+4 into the decode-side register that drives the PCD decode stage. Applies stall, flush and execute-stage redirect requests from the hazard unit, and keeps a count of instructions delivered to decode.

---
 rtl/fetch_stage.sv | 96 +++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: program counter and IF/ID pipeline register of the RV32I core.
// Handles stall, flush and execute-stage redirect, and counts delivered instructions.
module fetch_stage #(
    parameter int unsigned       WD       = 32,
    parameter logic [WD-1:0]     RESET_PC = '0,
    parameter logic [WD-1:0]     NOP      = WD'(32'h0000_0013)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          StallF,
    input  logic          StallD,
    input  logic          FlushD,
    input  logic          PCSrcE,
    input  logic [WD-1:0] PCTargetE,
    input  logic [WD-1:0] InstrF,
    output logic [WD-1:0] PCF,
    output logic [WD-1:0] InstrD,
    output logic [WD-1:0] PCD,
    output logic [WD-1:0] PCPlus4D,
    output logic          ValidD,
    output logic [31:0]   FetchCount
);

    logic [WD-1:0] pc_q, pc_d;
    logic [WD-1:0] pc_plus4;
    logic [WD-1:0] instr_q, instr_d;
    logic [WD-1:0] pcd_q, pcd_d;
    logic [WD-1:0] pcp4_q, pcp4_d;
    logic          valid_q, valid_d;
    logic [31:0]   cnt_q, cnt_d;
    logic          accept;

    assign pc_plus4 = pc_q + WD'(4);

    // Next PC: a redirect wins over a fetch stall; targets are word aligned.
    always_comb begin
        pc_d = pc_plus4;
        if (PCSrcE) begin
            pc_d = {PCTargetE[WD-1:2], 2'b00};
        end else if (StallF) begin
            pc_d = pc_q;
        end
    end

    // IF/ID next state: flush inserts a bubble and beats a decode stall.
    always_comb begin
        accept  = 1'b0;
        instr_d = instr_q;
        pcd_d   = pcd_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (FlushD) begin
            instr_d = NOP;
            pcd_d   = '0;
            pcp4_d  = '0;
            valid_d = 1'b0;
        end else if (!StallD) begin
            accept  = 1'b1;
            instr_d = InstrF;
            pcd_d   = pc_q;
            pcp4_d  = pc_plus4;
            valid_d = 1'b1;
        end
        if (accept) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // State update with synchronous reset; reset discards in-flight IF/ID data.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP;
            pcd_q   <= '0;
            pcp4_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcd_q   <= pcd_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign PCF        = pc_q;
    assign InstrD     = instr_q;
    assign PCD        = pcd_q;
    assign PCPlus4D   = pcp4_q;
    assign ValidD     = valid_q;
    assign FetchCount = cnt_q;

endmodule
